// File: rtl/vga_scan_driver.sv
// Raster-scan initiator: sweeps (p_row, p_col) over the frame, samples the
// renderer colour and drives registered RGB / HSYNC / VSYNC / video_on.
// Latency: outputs lag the pixel coordinates by one pixel; no backpressure.
module vga_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] color_data,
  output logic [9:0]  p_row,
  output logic [9:0]  p_col,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-bit divider is kept even for CLK_DIV=1; it simply never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [11:0]      r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_tick;

  logic w_pix_tick;
  logic w_act;
  logic w_h_pulse;
  logic w_v_pulse;
  logic w_frame_end;

  assign w_pix_tick  = (r_div_cnt == DIV_LAST);
  assign w_act       = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_h_pulse   = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_v_pulse   = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  // Last pixel of the last visible line: blanking starts on the next pixel.
  assign w_frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_ACT_LAST);

  // Clock divider producing the pixel enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_pix_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Horizontal / vertical scan counters, advanced once per pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        if (r_v_cnt == V_LAST) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 10'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Output stage: colour and syncs registered together so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb      <= 12'h000;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else if (w_pix_tick) begin
      r_rgb      <= w_act ? color_data : 12'h000;
      r_hsync    <= ~w_h_pulse;
      r_vsync    <= ~w_v_pulse;
      r_video_on <= w_act;
    end
  end

  // One-clk frame pulse marking entry into vertical blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_pix_tick && w_frame_end;
    end
  end

  assign p_col      = r_h_cnt;
  assign p_row      = r_v_cnt;
  assign rgb        = r_rgb;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign frame_tick = r_frame_tick;

endmodule
